// File: rtl/round_key_sequencer.sv
// round_key_sequencer: holds an AES expanded-key schedule and streams it
// out one 128-bit round key per valid/ready handshake, replayable per block.
//
// Parameters:
//   Nk          key length in 32-bit words (4/6/8); Nr and KW are derived
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   load_valid  key_words valid this cycle
//   load_ready  a load can be accepted (decoded from state, not registered)
//   key_words   flattened expanded key, word 0 in the top 32 bits
//   start       begin streaming the held schedule (honoured when LOADED)
//   dir         only with ROUND_KEY_REVERSE_EN: 1 streams rounds Nr..0
//   rk_valid    rk_data valid
//   rk_ready    consumer accepts rk_data
//   rk_data     current round key, lowest-numbered word in bits [127:96]
//   rk_index    true round number of rk_data
//   rk_last     rk_data is the final key of this pass
//   busy        streaming in progress
// Build option: define ROUND_KEY_REVERSE_EN to add the dir port.
module round_key_sequencer #(
   parameter  int Nk = 4,
   localparam int Nr = Nk + 6,
   localparam int KW = (4 * Nr + 4) * 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_valid,
   output logic          load_ready,
   input  logic [KW-1:0] key_words,
   input  logic          start,
`ifdef ROUND_KEY_REVERSE_EN
   input  logic          dir,
`endif
   output logic          rk_valid,
   input  logic          rk_ready,
   output logic [127:0]  rk_data,
   output logic [3:0]    rk_index,
   output logic          rk_last,
   output logic          busy
);

   localparam logic [3:0] LAST_UP = 4'(Nr);

   typedef enum logic [1:0] {
      IDLE,
      LOADED,
      STREAM
   } state_t;

   state_t        state, state_d;
   logic [KW-1:0] key_q, key_d;
   logic [KW-1:0] src, win;
   logic          rev_q, rev_d;
   logic          dir_in;
   logic          v_d, last_d, busy_d, upd;
   logic [3:0]    idx_d;
   logic [127:0]  data_d;
   logic          load_fire, hs;

`ifdef ROUND_KEY_REVERSE_EN
   assign dir_in = dir;
`else
   assign dir_in = 1'b0;
`endif

   assign load_ready = (state != STREAM);
   assign load_fire  = load_valid && load_ready;
   assign hs         = rk_valid && rk_ready;

   // A load accepted together with start must supply round 0 directly,
   // so the slice source bypasses the key register on a load edge.
   assign src    = load_fire ? key_words : key_q;
   assign win    = src << {idx_d, 7'd0};
   assign data_d = win[KW-1 -: 128];

   always_comb begin
      state_d = state;
      key_d   = src;
      rev_d   = rev_q;
      v_d     = rk_valid;
      idx_d   = rk_index;
      last_d  = rk_last;
      busy_d  = busy;
      upd     = 1'b0;
      unique case (state)
         IDLE: begin
            if (load_fire) state_d = LOADED;
         end
         LOADED: begin
            if (start) begin
               state_d = STREAM;
               rev_d   = dir_in;
               v_d     = 1'b1;
               busy_d  = 1'b1;
               upd     = 1'b1;
               idx_d   = dir_in ? LAST_UP : 4'd0;
               last_d  = 1'b0;
            end
         end
         STREAM: begin
            if (hs) begin
               if (rk_last) begin
                  // index is left at its end value: no wrap
                  state_d = LOADED;
                  v_d     = 1'b0;
                  last_d  = 1'b0;
                  busy_d  = 1'b0;
               end else begin
                  upd    = 1'b1;
                  idx_d  = rev_q ? rk_index - 4'd1
                                 : rk_index + 4'd1;
                  last_d = rev_q ? (idx_d == 4'd0)
                                 : (idx_d == LAST_UP);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         key_q    <= '0;
         rev_q    <= 1'b0;
         rk_valid <= 1'b0;
         rk_data  <= '0;
         rk_index <= '0;
         rk_last  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_d;
         key_q    <= key_d;
         rev_q    <= rev_d;
         rk_valid <= v_d;
         rk_index <= idx_d;
         rk_last  <= last_d;
         busy     <= busy_d;
         if (upd) rk_data <= data_d;
      end
   end

endmodule
